// File: rtl/j101_wbck_pkg.sv
// j101_wbck_pkg: shared width defaults, grant encoding and helpers for the write-back stage.
// Revision 1.0 - initial release.
`default_nettype none

`ifndef J101_XLEN
  `define J101_XLEN 32
`endif
`ifndef J101_RFIDX_WIDTH
  `define J101_RFIDX_WIDTH 5
`endif
`ifndef J101_WBCK_STARVE_MAX
  `define J101_WBCK_STARVE_MAX 4
`endif
`ifndef J101_WBCK_CNT_W
  `define J101_WBCK_CNT_W 4
`endif

package j101_wbck_pkg;

  localparam int XLEN_DEF        = `J101_XLEN;
  localparam int RFIDX_W_DEF     = `J101_RFIDX_WIDTH;
  localparam int STARVE_MAX_DEF  = `J101_WBCK_STARVE_MAX;
  localparam int WBCK_CNT_W      = `J101_WBCK_CNT_W;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_ALU   = 2'd1,
    GNT_LONGP = 2'd2
  } wbck_gnt_e;

  // The arbiter guarantees the grants are one-hot or idle; longp is checked first anyway.
  function automatic wbck_gnt_e gnt_encode(input logic alu_gnt, input logic longp_gnt);
    if (longp_gnt)    return GNT_LONGP;
    else if (alu_gnt) return GNT_ALU;
    else              return GNT_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/j101_wbck_arb.sv
// j101_wbck_arb: long-pipe-priority two-way arbiter with a saturating ALU anti-starvation streak.
// Revision 1.0 - initial release.
`default_nettype none

module j101_wbck_arb
  import j101_wbck_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = WBCK_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_alu_valid,
  input  logic i_longp_valid,
  output logic o_alu_gnt,
  output logic o_longp_gnt
);

  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("j101_wbck_arb: STARVE_MAX must lie in 1..15");
  end

  logic [CNT_W-1:0] r_streak;
  logic [CNT_W-1:0] w_streak_nxt;
  logic             w_starved;

  assign w_starved = (r_streak == c_starve_max);

  // Readys are held low throughout reset so nothing is accepted while the stage is cleared.
  assign o_longp_gnt = ~rst & i_longp_valid & ~(i_alu_valid & w_starved);
  assign o_alu_gnt   = ~rst & i_alu_valid & (~i_longp_valid | w_starved);

  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_alu_valid || o_alu_gnt) begin
      w_streak_nxt = '0;
    end else if (o_longp_gnt && !w_starved) begin
      w_streak_nxt = r_streak + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/j101_wbck.sv
// j101_wbck: write-back stage; arbitrates ALU vs long-pipe results and registers the regfile write port.
// Revision 1.0 - initial release.
`default_nettype none

module j101_wbck
  import j101_wbck_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int XLEN       = XLEN_DEF,
  parameter int RFIDX_W    = RFIDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
  input  logic               longp_wbck_i_err,
  output logic               wbck_dest_wen,
  output logic [RFIDX_W-1:0] wbck_dest_idx,
  output logic [XLEN-1:0]    wbck_dest_dat,
  output logic               longp_excp_o
);

  logic               w_alu_gnt;
  logic               w_longp_gnt;
  wbck_gnt_e          w_sel;
  logic               w_wen;
  logic               w_excp;
  logic [RFIDX_W-1:0] w_idx;
  logic [XLEN-1:0]    w_dat;

  logic               r_wen;
  logic               r_excp;
  logic [RFIDX_W-1:0] r_idx;
  logic [XLEN-1:0]    r_dat;

  j101_wbck_arb #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (WBCK_CNT_W)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .i_alu_valid   (alu_wbck_i_valid),
    .i_longp_valid (longp_wbck_i_valid),
    .o_alu_gnt     (w_alu_gnt),
    .o_longp_gnt   (w_longp_gnt)
  );

  assign alu_wbck_i_ready   = w_alu_gnt;
  assign longp_wbck_i_ready = w_longp_gnt;

  // A faulting long-pipe result still updates idx/dat but turns the write into an exception slot.
  always_comb begin
    w_sel  = gnt_encode(w_alu_gnt, w_longp_gnt);
    w_wen  = 1'b0;
    w_excp = 1'b0;
    w_idx  = r_idx;
    w_dat  = r_dat;
    case (w_sel)
      GNT_ALU: begin
        w_wen = 1'b1;
        w_idx = alu_wbck_i_rdidx;
        w_dat = alu_wbck_i_wdat;
      end
      GNT_LONGP: begin
        w_wen  = ~longp_wbck_i_err;
        w_excp = longp_wbck_i_err;
        w_idx  = longp_wbck_i_rdidx;
        w_dat  = longp_wbck_i_wdat;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen  <= 1'b0;
      r_excp <= 1'b0;
      r_idx  <= '0;
      r_dat  <= '0;
    end else begin
      r_wen  <= w_wen;
      r_excp <= w_excp;
      r_idx  <= w_idx;
      r_dat  <= w_dat;
    end
  end

  assign wbck_dest_wen = r_wen;
  assign wbck_dest_idx = r_idx;
  assign wbck_dest_dat = r_dat;
  assign longp_excp_o  = r_excp;

endmodule

`default_nettype wire

// File: tb/tb_j101_wbck.sv
// tb_j101_wbck: directed self-checking bench for the j101_wbck write-back stage.
// Revision 1.0 - initial release.
`default_nettype none

module tb_j101_wbck;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;

  logic               clk;
  logic               rst;
  logic               alu_valid;
  logic               alu_ready;
  logic [XLEN-1:0]    alu_wdat;
  logic [RFIDX_W-1:0] alu_rdidx;
  logic               lp_valid;
  logic               lp_ready;
  logic [XLEN-1:0]    lp_wdat;
  logic [RFIDX_W-1:0] lp_rdidx;
  logic               lp_err;
  logic               wen;
  logic [RFIDX_W-1:0] widx;
  logic [XLEN-1:0]    wdat;
  logic               excp;

  int n_checks;
  int n_fail;

  j101_wbck #(
    .STARVE_MAX (4),
    .XLEN       (XLEN),
    .RFIDX_W    (RFIDX_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_wbck_i_valid   (alu_valid),
    .alu_wbck_i_ready   (alu_ready),
    .alu_wbck_i_wdat    (alu_wdat),
    .alu_wbck_i_rdidx   (alu_rdidx),
    .longp_wbck_i_valid (lp_valid),
    .longp_wbck_i_ready (lp_ready),
    .longp_wbck_i_wdat  (lp_wdat),
    .longp_wbck_i_rdidx (lp_rdidx),
    .longp_wbck_i_err   (lp_err),
    .wbck_dest_wen      (wen),
    .wbck_dest_idx      (widx),
    .wbck_dest_dat      (wdat),
    .longp_excp_o       (excp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lp_next;
  logic exp_alu;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_wdat = '0; alu_rdidx = '0;
    lp_valid = 1'b1; lp_wdat = 32'h1234; lp_rdidx = 5'd5; lp_err = 1'b0;

    // Reset state: readys low even with a pending valid
    repeat (2) @(posedge clk);
    #1;
    check("rst_lp_ready", lp_ready, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_wen", wen, 0);
    check("rst_idx", widx, 0);
    check("rst_dat", wdat, 0);
    check("rst_excp", excp, 0);

    // Longp transfer, then async reset mid-cycle clears the outputs before the next edge
    rst = 1'b0;
    #1;
    check("lp_only_ready", lp_ready, 1);
    tick();
    check("lp5_wen", wen, 1);
    check("lp5_idx", widx, 5);
    check("lp5_dat", wdat, 32'h1234);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_wen", wen, 0);
    check("async_rst_idx", widx, 0);
    check("async_rst_dat", wdat, 0);
    check("async_rst_ready", lp_ready, 0);
    lp_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_wen", wen, 0);
    check("post_rst_idx", widx, 0);

    // Single ALU result
    alu_valid = 1'b1; alu_rdidx = 5'd3; alu_wdat = 32'hDEADBEEF;
    #1;
    check("alu_only_ready", alu_ready, 1);
    check("alu_only_lp_ready", lp_ready, 0);
    tick();
    alu_valid = 1'b0;
    check("alu3_wen", wen, 1);
    check("alu3_idx", widx, 3);
    check("alu3_dat", wdat, 32'hDEADBEEF);
    tick();
    check("idle_wen", wen, 0);
    check("idle_idx_hold", widx, 3);
    check("idle_dat_hold", wdat, 32'hDEADBEEF);

    // Collision: longp first, ALU on the following cycle
    alu_valid = 1'b1; alu_rdidx = 5'd1; alu_wdat = 32'h11;
    lp_valid = 1'b1; lp_rdidx = 5'd2; lp_wdat = 32'h22;
    #1;
    check("coll_lp_ready", lp_ready, 1);
    check("coll_alu_ready", alu_ready, 0);
    tick();
    lp_valid = 1'b0;
    check("coll_lp_wen", wen, 1);
    check("coll_lp_idx", widx, 2);
    check("coll_lp_dat", wdat, 32'h22);
    #1;
    check("coll_alu_ready2", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("coll_alu_idx", widx, 1);
    check("coll_alu_wen", wen, 1);
    tick();

    // Starvation bound: four longp grants, one ALU grant, then longp again
    alu_valid = 1'b1; alu_rdidx = 5'd9; alu_wdat = 32'h99;
    lp_next = 10;
    for (int k = 0; k < 7; k++) begin
      exp_alu = (k == 4);
      lp_valid = 1'b1;
      lp_rdidx = RFIDX_W'(lp_next);
      lp_wdat  = 32'h100 + 32'(lp_next);
      #1;
      check($sformatf("starve%0d_alu_ready", k), alu_ready, exp_alu);
      check($sformatf("starve%0d_lp_ready", k), lp_ready, !exp_alu);
      tick();
      if (exp_alu) begin
        check($sformatf("starve%0d_idx", k), widx, 9);
        alu_rdidx = 5'd20; alu_wdat = 32'h20;
      end else begin
        check($sformatf("starve%0d_idx", k), widx, lp_next);
        check($sformatf("starve%0d_dat", k), wdat, 32'h100 + 32'(lp_next));
        lp_next++;
      end
    end
    alu_valid = 1'b0; lp_valid = 1'b0;
    tick();

    // Faulting long-pipe result: no write, one-cycle exception pulse
    lp_valid = 1'b1; lp_err = 1'b1; lp_rdidx = 5'd7; lp_wdat = 32'h55;
    #1;
    check("err_ready", lp_ready, 1);
    tick();
    lp_valid = 1'b0; lp_err = 1'b0;
    check("err_wen", wen, 0);
    check("err_excp", excp, 1);
    check("err_idx", widx, 7);
    tick();
    check("err_excp_end", excp, 0);
    check("err_wen_end", wen, 0);

    // Throughput: eight back-to-back ALU results
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1'b1;
      alu_rdidx = RFIDX_W'(i);
      alu_wdat  = 32'(i) * 32'h10;
      tick();
      check($sformatf("tput%0d_wen", i), wen, 1);
      check($sformatf("tput%0d_idx", i), widx, i);
      check($sformatf("tput%0d_dat", i), wdat, 32'(i) * 32'h10);
    end
    alu_valid = 1'b0;
    tick();
    check("tput_end_wen", wen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
